// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, the MUL/DIV default latency and the stall-counter ceiling.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1,
      HALT    = 2'd2
   } ctrl_state_t;

   localparam int          MD_CYCLES_DEF = 4;
   localparam logic [15:0] STALL_SAT     = 16'hFFFF;

   // True when the ID instruction reads the register a load in EX is about to write.
   function automatic logic load_use_match(
      input logic       is_load,
      input logic [3:0] rd,
      input logic       uses_rs1,
      input logic [3:0] rs1,
      input logic       uses_rs2,
      input logic [3:0] rs2
   );
      logic hit_rs1;
      logic hit_rs2;
      hit_rs1 = uses_rs1 & (rs1 == rd);
      hit_rs2 = uses_rs2 & (rs2 == rd);
      return is_load & (hit_rs1 | hit_rs2);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous active-low clear that sticks at its ceiling.
// The clear wins over the enable.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int          W   = 16,
   parameter logic [15:0] MAX = STALL_SAT
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;
   logic [W-1:0] max_s;

   assign max_s = MAX[W-1:0];

   // Count register: clear, saturating increment, or hold.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_r <= {W{1'b0}};
      end else if (en && (count_r != max_s)) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control unit: load-use stalls, taken-branch flushes, MUL/DIV occupancy of EX,
// HALT latching and a saturating stall-cycle counter.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_rs1,
   input  logic [3:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [3:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_is_muldiv,
   input  logic        ex_is_halt,
   input  logic        branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_hold,
   output logic        idex_flush,
   output logic        exmem_bubble,
   output logic        halted,
   output logic [15:0] stall_count
);

   // The detect cycle in RUN is the first hold, so MD_BUSY only needs MD_CYCLES-2 more.
   localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

   ctrl_state_t state_r;
   ctrl_state_t next_state_s;
   logic [3:0]  md_cnt_r;
   logic [3:0]  next_md_cnt_s;
   logic        load_use_s;
   logic        count_en_s;

   assign load_use_s = load_use_match(ex_is_load, ex_rd, id_uses_rs1, id_rs1,
                                      id_uses_rs2, id_rs2);

   // Output decode and next-state selection.
   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_hold     = 1'b0;
      idex_flush    = 1'b0;
      exmem_bubble  = 1'b0;
      halted        = 1'b0;
      next_state_s  = state_r;
      next_md_cnt_s = md_cnt_r;

      if (!rst) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         ifid_flush    = 1'b1;
         idex_flush    = 1'b1;
         exmem_bubble  = 1'b1;
         next_state_s  = RUN;
         next_md_cnt_s = 4'd0;
      end else begin
         case (state_r)
            RUN: begin
               if (ex_is_halt) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  ifid_flush   = 1'b1;
                  idex_flush   = 1'b1;
                  next_state_s = HALT;
               end else if (branch_taken) begin
                  ifid_flush   = 1'b1;
                  idex_flush   = 1'b1;
                  next_state_s = RUN;
               end else if (ex_is_muldiv) begin
                  pc_write      = 1'b0;
                  ifid_write    = 1'b0;
                  idex_hold     = 1'b1;
                  exmem_bubble  = 1'b1;
                  next_md_cnt_s = MD_LOAD;
                  next_state_s  = MD_BUSY;
               end else if (load_use_s) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_flush   = 1'b1;
                  next_state_s = RUN;
               end else begin
                  next_state_s = RUN;
               end
            end
            MD_BUSY: begin
               if (md_cnt_r != 4'd0) begin
                  pc_write      = 1'b0;
                  ifid_write    = 1'b0;
                  idex_hold     = 1'b1;
                  exmem_bubble  = 1'b1;
                  next_md_cnt_s = md_cnt_r - 4'd1;
                  next_state_s  = MD_BUSY;
               end else begin
                  next_state_s = RUN;
               end
            end
            HALT: begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               ifid_flush   = 1'b1;
               idex_flush   = 1'b1;
               halted       = 1'b1;
               next_state_s = HALT;
            end
            default: begin
               // Unreachable encoding: squash the pipe and recover into RUN.
               pc_write      = 1'b0;
               ifid_write    = 1'b0;
               ifid_flush    = 1'b1;
               idex_flush    = 1'b1;
               next_state_s  = RUN;
               next_md_cnt_s = 4'd0;
            end
         endcase
      end
   end

   // FSM state and MUL/DIV down-counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= RUN;
         md_cnt_r <= 4'd0;
      end else begin
         state_r  <= next_state_s;
         md_cnt_r <= next_md_cnt_s;
      end
   end

   assign count_en_s = ~pc_write & ((state_r == RUN) | (state_r == MD_BUSY));

   sat_counter #(
      .W   (16),
      .MAX (STALL_SAT)
   ) u_stall_cnt (
      .clk   (clk),
      .clr_n (rst),
      .en    (count_en_s),
      .count (stall_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_CYCLES=4 main instance, MD_CYCLES=2 side instance).
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic        ex_is_load, ex_is_muldiv, ex_is_halt, branch_taken;
   logic        muldiv2;

   logic        pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_bubble, halted;
   logic [15:0] stall_count;
   logic        pc_write2, ifid_write2, ifid_flush2, idex_hold2, idex_flush2, exmem_bubble2, halted2;
   logic [15:0] stall_count2;

   int n_chk;
   int n_pass;

   hazard_ctrl #(.MD_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv),
      .ex_is_halt(ex_is_halt), .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_hold(idex_hold), .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
      .halted(halted), .stall_count(stall_count)
   );

   hazard_ctrl #(.MD_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_muldiv(muldiv2),
      .ex_is_halt(ex_is_halt), .branch_taken(branch_taken),
      .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
      .idex_hold(idex_hold2), .idex_flush(idex_flush2), .exmem_bubble(exmem_bubble2),
      .halted(halted2), .stall_count(stall_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      id_rs1 = 4'd0; id_rs2 = 4'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 4'd0; ex_is_load = 1'b0; ex_is_muldiv = 1'b0; ex_is_halt = 1'b0;
      branch_taken = 1'b0; muldiv2 = 1'b0;
   endtask

   // Packs the six control outputs of the main instance {pc,ifw,iff,hold,idf,bub}.
   function automatic logic [5:0] ctl();
      return {pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_bubble};
   endfunction

   function automatic logic [5:0] ctl2();
      return {pc_write2, ifid_write2, ifid_flush2, idex_hold2, idex_flush2, exmem_bubble2};
   endfunction

   localparam logic [5:0] C_DEF   = 6'b110000;
   localparam logic [5:0] C_RST   = 6'b001011;
   localparam logic [5:0] C_LU    = 6'b000010;
   localparam logic [5:0] C_HOLD  = 6'b000101;
   localparam logic [5:0] C_BR    = 6'b111010;
   localparam logic [5:0] C_HALT  = 6'b001010;

   initial begin
      n_chk = 0;
      n_pass = 0;
      idle();
      rst = 1'b0;

      // Reset held for two edges.
      sample();
      check("rst_ctl", {26'd0, ctl()}, {26'd0, C_RST});
      check("rst_halted", {31'd0, halted}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      sample();
      check("post_rst_ctl", {26'd0, ctl()}, {26'd0, C_DEF});
      check("post_rst_cnt", {16'd0, stall_count}, 32'd0);

      // Load-use on rs2: exactly one stall cycle.
      tick();
      ex_is_load = 1'b1; ex_rd = 4'd5; id_uses_rs2 = 1'b1; id_rs2 = 4'd5;
      sample();
      check("lu_ctl", {26'd0, ctl()}, {26'd0, C_LU});
      tick();
      idle();
      sample();
      check("lu_after_ctl", {26'd0, ctl()}, {26'd0, C_DEF});
      check("lu_cnt", {16'd0, stall_count}, 32'd1);

      // Same registers but rs2 not used: no stall.
      tick();
      ex_is_load = 1'b1; ex_rd = 4'd5; id_uses_rs2 = 1'b0; id_rs2 = 4'd5;
      sample();
      check("lu_unused_ctl", {26'd0, ctl()}, {26'd0, C_DEF});
      tick();
      idle();
      sample();
      check("lu_unused_cnt", {16'd0, stall_count}, 32'd1);

      // R0 destination matches like any other register.
      tick();
      ex_is_load = 1'b1; ex_rd = 4'd0; id_uses_rs1 = 1'b1; id_rs1 = 4'd0;
      sample();
      check("lu_r0_ctl", {26'd0, ctl()}, {26'd0, C_LU});
      tick();
      idle();
      sample();
      check("lu_r0_cnt", {16'd0, stall_count}, 32'd2);

      // MUL/DIV with MD_CYCLES=4: three hold cycles, then advance.
      tick();
      ex_is_muldiv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("md4_hold%0d", i), {26'd0, ctl()}, {26'd0, C_HOLD});
         tick();
      end
      sample();
      check("md4_release", {26'd0, ctl()}, {26'd0, C_DEF});
      tick();
      ex_is_muldiv = 1'b0;
      sample();
      check("md4_after", {26'd0, ctl()}, {26'd0, C_DEF});
      check("md4_cnt", {16'd0, stall_count}, 32'd5);

      // MUL/DIV with MD_CYCLES=2: one hold cycle only.
      tick();
      muldiv2 = 1'b1;
      sample();
      check("md2_hold", {26'd0, ctl2()}, {26'd0, C_HOLD});
      tick();
      sample();
      check("md2_release", {26'd0, ctl2()}, {26'd0, C_DEF});
      tick();
      muldiv2 = 1'b0;
      sample();
      check("md2_after", {26'd0, ctl2()}, {26'd0, C_DEF});
      check("md2_cnt", {16'd0, stall_count2}, 32'd3);

      // Taken branch beats a simultaneous load-use.
      tick();
      branch_taken = 1'b1;
      ex_is_load = 1'b1; ex_rd = 4'd7; id_uses_rs1 = 1'b1; id_rs1 = 4'd7;
      sample();
      check("br_lu_ctl", {26'd0, ctl()}, {26'd0, C_BR});
      tick();
      idle();
      sample();
      check("br_lu_cnt", {16'd0, stall_count}, 32'd5);

      // Reset during the second MUL/DIV hold cycle abandons it.
      tick();
      ex_is_muldiv = 1'b1;
      sample();
      check("mdrst_hold1", {26'd0, ctl()}, {26'd0, C_HOLD});
      tick();
      rst = 1'b0;
      sample();
      check("mdrst_forced", {26'd0, ctl()}, {26'd0, C_RST});
      tick();
      rst = 1'b1;
      ex_is_muldiv = 1'b0;
      sample();
      check("mdrst_run", {26'd0, ctl()}, {26'd0, C_DEF});
      check("mdrst_cnt", {16'd0, stall_count}, 32'd0);

      // HALT latches, holds flushes, and only reset clears it.
      tick();
      ex_is_halt = 1'b1;
      sample();
      check("halt_enter_ctl", {26'd0, ctl()}, {26'd0, C_HALT});
      check("halt_enter_halted", {31'd0, halted}, 32'd0);
      tick();
      idle();
      for (int i = 0; i < 20; i++) begin
         sample();
         check($sformatf("halt_hold%0d", i), {25'd0, halted, ctl()}, {25'd0, 1'b1, C_HALT});
         tick();
      end
      check("halt_cnt", {16'd0, stall_count}, 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      sample();
      check("halt_rst_halted", {31'd0, halted}, 32'd0);
      check("halt_rst_ctl", {26'd0, ctl()}, {26'd0, C_DEF});

      // Saturation: hold a load-use match for 65 540 cycles.
      tick();
      ex_is_load = 1'b1; ex_rd = 4'd3; id_uses_rs1 = 1'b1; id_rs1 = 4'd3;
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
      end
      #1;
      check("sat_cnt", {16'd0, stall_count}, 32'h0000FFFF);
      tick();
      check("sat_stick", {16'd0, stall_count}, 32'h0000FFFF);
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 16-bit 5-stage datapath. It watches the instructions in ID and EX. It generates the PC, IF/ID and ID/EX write-enable, hold and flush controls, plus the bubble control for EX/MEM. It sequences three cases: load-use stalls, taken-branch flushes, and multi-cycle MUL/DIV occupancy of EX. It also latches HALT and keeps a saturating stall-cycle counter for performance debug.

## Interface
- MD_CYCLES, 4, total cycles a MUL/DIV instruction occupies EX; legal range 2..15
- clk  in  1  the single system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- id_rs1, id_rs2  in  4  source register numbers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source
- ex_rd  in  4  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_is_muldiv  in  1  EX instruction is MUL or DIV
- ex_is_halt  in  1  EX instruction is HALT
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_hold  out  1  ID/EX keeps its contents
- idex_flush  out  1  ID/EX loads a NOP
- exmem_bubble  out  1  EX/MEM loads a NOP
- halted  out  1  core is halted
- stall_count  out  16  saturating count of stall cycles

## Operation
- The FSM has three states: RUN, MD_BUSY and HALT. The down-counter md_cnt is 4 bits.
- Outputs are combinational from the state, md_cnt and the inputs.
- Default output values: pc_write=1, ifid_write=1, all flush, hold and bubble outputs 0.
- RUN evaluates the following conditions in priority order; the first that matches applies:
  1. **ex_is_halt**: go to HALT. This cycle: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  2. **branch_taken**: ifid_flush=1 and idex_flush=1, which discards the two younger instructions. pc_write stays 1. Stay in RUN.
  3. **ex_is_muldiv**:
     - pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1.
     - md_cnt <= MD_CYCLES-2.
     - Go to MD_BUSY.
  4. **Load-use hazard**: ex_is_load and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
     - pc_write=0, ifid_write=0, idex_flush=1, giving a one-bubble stall.
     - Stay in RUN. Next cycle the load is in MEM, so the hazard clears by itself.
- MD_BUSY:
  - If md_cnt != 0: same hold outputs as RUN case 3, and md_cnt decrements.
  - If md_cnt == 0: default outputs, so the pipeline advances; go to RUN.
  - Inputs other than md_cnt are ignored in MD_BUSY.
- HALT:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, halted=1.
  - Leaves HALT only through reset.
- stall_count increments by 1 in every RUN or MD_BUSY cycle where pc_write==0.
  - This includes the cycle that enters HALT and the MUL/DIV detect cycle.
  - It saturates at 16'hFFFF.
  - It does not count in HALT.
- ex_rd==0 matching is not special-cased; a match on R0 stalls like any other register.

## Timing
- Reset:
  - When rst is low at a clock edge: state<=RUN, md_cnt<=0, stall_count<=0.
  - While rst is low, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_bubble=1, idex_hold=0, halted=0.
  - Reset in mid MD_BUSY or in HALT abandons the operation immediately.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots and 0 stall cycles.
- MUL/DIV holds for MD_CYCLES-1 cycles, giving EX occupancy of exactly MD_CYCLES.
  - With MD_CYCLES=2: hold in the RUN detect cycle only; MD_BUSY lasts 1 cycle with md_cnt==0 and advances.
- Simultaneous events: branch_taken with a load-use match means the flush wins, with no stall and no stall_count increment. ex_is_halt overrides everything.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum: RUN=2'd0, MD_BUSY=2'd1, HALT=2'd2
  - MD_CYCLES_DEF=4
  - the 16-bit saturation constant
- Sub-module sat_counter (16-bit, enable, synchronous active-low clear, saturates at max) is instantiated for stall_count.
- All other logic is flat in hazard_ctrl.

## Test plan
- **Reset**: rst=0 for 2 cycles, then deassert with no hazards. Required: flush=1 and pc_write=0 during reset; afterward pc_write=1, ifid_write=1, stall_count=0.
- **Load-use**: ex_is_load=1, ex_rd=5, id_uses_rs2=1, id_rs2=5. Required: exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1. Repeat with id_uses_rs2=0: no stall.
- **MUL/DIV, MD_CYCLES=4**: ex_is_muldiv=1. Required: 3 consecutive cycles of pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1; 4th cycle defaults; stall_count=3. Repeat with MD_CYCLES=2: 1 hold cycle.
- **Branch with load-use**: branch_taken=1 together with a load-use match. Required: ifid_flush=1, idex_flush=1, pc_write=1, stall_count unchanged.
- **Halt**: ex_is_halt=1. Required: halted=1 from the next cycle and flushes held for 20 cycles. Then rst=0 for one edge: halted=0, state RUN.
- **Reset in MD_BUSY, plus saturation**: assert rst during the 2nd hold cycle; required: next cycle RUN with no hold. Separately, force 65 540 stall cycles; required: stall_count=16'hFFFF.
